prbs_gen_chk: RTL

Parametrised PRBS pattern generator and self-synchronising pattern checker sharing one clock domain. It supports PRBS7/15/23/31, output/input inversion, single-bit error injection, a lock state machine and a saturating error counter. It is instantiated under the Tiny Tapeout top wrapper: the generator drives a `uo_out` pin and the checker samples a `ui_in` pin, for link and loopback testing.

---
 rtl/prbs_gen_chk.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 pattern generator and self-synchronising checker with lock FSM,
// single-bit error injection and a saturating error counter.
module prbs_gen_chk #(
    parameter int unsigned PRBS_ORDER = 31,
    parameter int unsigned ERR_W      = 16,
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned UNLOCK_CNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gen_en,
    input  logic             gen_inv,
    input  logic             err_inject,
    output logic             gen_out,
    input  logic             chk_en,
    input  logic             chk_in,
    input  logic             chk_inv,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int unsigned N     = PRBS_ORDER;
    localparam int unsigned T     = (N == 7)  ? 6  :
                                    (N == 15) ? 14 :
                                    (N == 23) ? 18 : 28;
    localparam int unsigned CNT_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    generate
        if (!(N == 7 || N == 15 || N == 23 || N == 31)) begin : g_bad_order
            $error("prbs_gen_chk: PRBS_ORDER must be 7, 15, 23 or 31");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_e;

    logic [N-1:0]     g_q, g_d;
    logic             gen_out_q, gen_out_d;
    logic [N-1:0]     s_q, s_d;
    logic [CNT_W-1:0] mc_q, mc_d;
    logic [CNT_W-1:0] uc_q, uc_d;
    chk_state_e       state_q, state_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             rx_bit;
    logic             exp_bit;
    logic             miss;
    logic             counted;

    // Generator: err_inject only touches the output bit, never the LFSR
    always_comb begin
        g_d       = g_q;
        gen_out_d = gen_out_q;
        if (gen_en) begin
            gen_out_d = g_q[N-1] ^ gen_inv ^ err_inject;
            g_d       = {g_q[N-2:0], g_q[N-1] ^ g_q[T-1]};
        end
    end

    // Checker FSM: self-seeds from the line in SEARCH, free-runs in LOCKED
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        mc_d        = mc_q;
        uc_d        = uc_q;
        err_cnt_d   = err_cnt_q;
        counted     = 1'b0;
        rx_bit      = chk_in ^ chk_inv;
        exp_bit     = s_q[N-1] ^ s_q[T-1];
        miss        = (rx_bit != exp_bit);

        if (chk_en) begin
            unique case (state_q)
                ST_SEARCH: begin
                    s_d = {s_q[N-2:0], rx_bit};
                    if (!miss && (s_q != '0)) begin
                        mc_d = mc_q + CNT_W'(1);
                    end else begin
                        mc_d = '0;
                    end
                    if (mc_d == CNT_W'(LOCK_CNT)) begin
                        state_d = ST_LOCKED;
                        mc_d    = '0;
                    end
                end
                ST_LOCKED: begin
                    s_d = {s_q[N-2:0], exp_bit};
                    if (miss) begin
                        counted = 1'b1;
                        uc_d    = uc_q + CNT_W'(1);
                        if (uc_d == CNT_W'(UNLOCK_CNT)) begin
                            state_d = ST_SEARCH;
                            uc_d    = '0;
                            mc_d    = '0;
                        end
                    end else begin
                        uc_d = '0;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        // A clear coinciding with a counted error keeps that error
        if (err_clr) begin
            err_cnt_d = counted ? ERR_W'(1) : '0;
        end else if (counted && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end

        err_pulse_d = counted;
        locked_d    = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q         <= N'(1);
            gen_out_q   <= 1'b0;
            s_q         <= '0;
            mc_q        <= '0;
            uc_q        <= '0;
            state_q     <= ST_SEARCH;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            g_q         <= g_d;
            gen_out_q   <= gen_out_d;
            s_q         <= s_d;
            mc_q        <= mc_d;
            uc_q        <= uc_d;
            state_q     <= state_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign gen_out   = gen_out_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule
